// File: rtl/axi_bridge_ip_tx_pkg.sv
// Shared types, header layout and FIFO entry layout for the AXI->UCIe TX bridge.
// Ingress packs entries as {tlast, tuser, tkeep, tdata}; egress unpacks with the same offsets.
package axi_bridge_ip_tx_pkg;

  typedef enum logic [1:0] {
    EG_IDLE = 2'd0,
    EG_DATA = 2'd1,
    EG_DROP = 2'd2
  } eg_state_e;

  localparam int HDR_TUSER_LSB = 0;
  localparam int HDR_SEQ_LSB   = 16;
  localparam int HDR_SEQ_W     = 8;

  function automatic int entry_tdata_lsb();
    return 0;
  endfunction

  function automatic int entry_tkeep_lsb(input int data_w);
    return data_w;
  endfunction

  function automatic int entry_tuser_lsb(input int data_w);
    return data_w + data_w / 8;
  endfunction

  function automatic int entry_tlast_pos(input int data_w, input int tuser_w);
    return data_w + data_w / 8 + tuser_w;
  endfunction

  function automatic int entry_w(input int data_w, input int tuser_w);
    return data_w + data_w / 8 + tuser_w + 1;
  endfunction

endpackage

// File: rtl/axi_bridge_ip_tx_credit_ctr.sv
// Link credit counter: reloads from credit_init while the link is down,
// otherwise tracks consume/return and saturates at all-ones with an overflow pulse.
module axi_bridge_ip_tx_credit_ctr
  import axi_bridge_ip_tx_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                link_up,
  input  logic [CREDIT_W-1:0] credit_init,
  input  logic                consume,
  input  logic                credit_return,
  output logic [CREDIT_W-1:0] credits,
  output logic                ovf_pulse
);

  logic at_max;

  assign at_max = (credits == {CREDIT_W{1'b1}});

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credits   <= '0;
      ovf_pulse <= 1'b0;
    end else if (!link_up) begin
      credits   <= credit_init;
      ovf_pulse <= 1'b0;
    end else begin
      ovf_pulse <= 1'b0;
      if (consume && !credit_return) begin
        credits <= credits - 1'b1;
      end else if (!consume && credit_return) begin
        // a return beyond the counter range is lost; flag it instead of wrapping
        if (at_max) begin
          ovf_pulse <= 1'b1;
        end else begin
          credits <= credits + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axi_bridge_ip_tx_egress.sv
// TX egress: frames FIFO entries as one header beat plus data beats toward the link,
// under credit flow control, truncating packets that exceed the CSR beat limit.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | between packets; header beat is emitted when a packet may start
// ST_DATA | forwarding data beats, one FIFO pop per loaded beat
// ST_DROP | packet truncated; popping and discarding until its tlast
module axi_bridge_ip_tx_egress
  import axi_bridge_ip_tx_pkg::*;
#(
  parameter int DATA_W   = 256,
  parameter int TUSER_W  = 16,
  parameter int CREDIT_W = 8
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  fifo_empty,
  input  logic [DATA_W+DATA_W/8+TUSER_W:0]      fifo_rdata,
  output logic                                  fifo_pop,
  input  logic                                  bridge_enable,
  input  logic                                  link_up,
  input  logic [7:0]                            max_pkt_beats,
  input  logic [CREDIT_W-1:0]                   credit_init,
  input  logic                                  credit_return,
  output logic                                  m_tx_valid,
  input  logic                                  m_tx_ready,
  output logic [DATA_W-1:0]                     m_tx_data,
  output logic [DATA_W/8-1:0]                   m_tx_keep,
  output logic                                  m_tx_last,
  output logic                                  m_tx_hdr,
  output logic [CREDIT_W-1:0]                   credits_avail,
  output logic                                  pkt_sent_pulse,
  output logic                                  ev_err_pkt_too_long_pulse,
  output logic                                  ev_err_credit_ovf_pulse
);

  localparam int KEEP_W    = DATA_W / 8;
  localparam int TDATA_LSB = entry_tdata_lsb();
  localparam int TKEEP_LSB = entry_tkeep_lsb(DATA_W);
  localparam int TUSER_LSB = entry_tuser_lsb(DATA_W);
  localparam int TLAST_POS = entry_tlast_pos(DATA_W, TUSER_W);

  localparam logic [1:0] ST_IDLE = EG_IDLE;
  localparam logic [1:0] ST_DATA = EG_DATA;
  localparam logic [1:0] ST_DROP = EG_DROP;

  logic [1:0]           state;
  logic [7:0]           seq;
  logic [7:0]           beat_cnt;

  logic [DATA_W-1:0]    ent_tdata;
  logic [KEEP_W-1:0]    ent_tkeep;
  logic [TUSER_W-1:0]   ent_tuser;
  logic                 ent_tlast;
  logic [DATA_W-1:0]    hdr_data;

  logic                 slot_free;
  logic                 credit_ok;
  logic                 can_load;
  logic                 load_hdr;
  logic                 load_data;
  logic                 drop_pop;
  logic                 limit_hit;

  assign ent_tdata = fifo_rdata[TDATA_LSB +: DATA_W];
  assign ent_tkeep = fifo_rdata[TKEEP_LSB +: KEEP_W];
  assign ent_tuser = fifo_rdata[TUSER_LSB +: TUSER_W];
  assign ent_tlast = fifo_rdata[TLAST_POS];

  always_comb begin
    hdr_data = '0;
    hdr_data[HDR_TUSER_LSB +: TUSER_W] = ent_tuser;
    hdr_data[HDR_SEQ_LSB +: HDR_SEQ_W] = seq;
  end

  assign slot_free = !m_tx_valid || m_tx_ready;
  assign credit_ok = (credits_avail != '0);
  assign can_load  = link_up && slot_free && credit_ok && !fifo_empty;
  assign load_hdr  = (state == ST_IDLE) && can_load && bridge_enable;
  assign load_data = (state == ST_DATA) && can_load;
  assign drop_pop  = (state == ST_DROP) && link_up && !fifo_empty;
  assign fifo_pop  = load_data || drop_pop;

  // beat_cnt counts data beats already loaded, so this beat is number beat_cnt+1
  assign limit_hit = (max_pkt_beats != 8'd0) && ((beat_cnt + 8'd1) == max_pkt_beats);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= ST_IDLE;
      seq      <= '0;
      beat_cnt <= '0;
    end else if (!link_up) begin
      state    <= ST_IDLE;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_hdr) begin
            state    <= ST_DATA;
            beat_cnt <= '0;
          end
        end
        ST_DATA: begin
          if (load_data) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (ent_tlast) begin
              state <= ST_IDLE;
              seq   <= seq + 8'd1;
            end else if (limit_hit) begin
              state <= ST_DROP;
            end
          end
        end
        ST_DROP: begin
          if (drop_pop && ent_tlast) begin
            state <= ST_IDLE;
            seq   <= seq + 8'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      m_tx_valid <= 1'b0;
      m_tx_data  <= '0;
      m_tx_keep  <= '0;
      m_tx_last  <= 1'b0;
      m_tx_hdr   <= 1'b0;
    end else if (!link_up) begin
      m_tx_valid <= 1'b0;
      m_tx_last  <= 1'b0;
      m_tx_hdr   <= 1'b0;
    end else if (load_hdr) begin
      m_tx_valid <= 1'b1;
      m_tx_data  <= hdr_data;
      m_tx_keep  <= '1;
      m_tx_last  <= 1'b0;
      m_tx_hdr   <= 1'b1;
    end else if (load_data) begin
      m_tx_valid <= 1'b1;
      m_tx_data  <= ent_tdata;
      m_tx_keep  <= ent_tkeep;
      m_tx_last  <= ent_tlast || limit_hit;
      m_tx_hdr   <= 1'b0;
    end else if (m_tx_ready) begin
      m_tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pkt_sent_pulse            <= 1'b0;
      ev_err_pkt_too_long_pulse <= 1'b0;
    end else begin
      pkt_sent_pulse            <= link_up && m_tx_valid && m_tx_ready && m_tx_last;
      ev_err_pkt_too_long_pulse <= load_data && !ent_tlast && limit_hit;
    end
  end

  axi_bridge_ip_tx_credit_ctr #(
    .CREDIT_W (CREDIT_W)
  ) u_credit_ctr (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .link_up       (link_up),
    .credit_init   (credit_init),
    .consume       (load_hdr || load_data),
    .credit_return (credit_return),
    .credits       (credits_avail),
    .ovf_pulse     (ev_err_credit_ovf_pulse)
  );

endmodule

// File: tb/tb_axi_bridge_ip_tx_egress.sv
// Directed bench for the TX egress framer: FIFO model, beat capture and hand-computed beat lists.
module tb_axi_bridge_ip_tx_egress;

  localparam int DATA_W   = 32;
  localparam int TUSER_W  = 16;
  localparam int CREDIT_W = 8;
  localparam int KEEP_W   = DATA_W / 8;
  localparam int ENTRY_W  = DATA_W + KEEP_W + TUSER_W + 1;
  localparam int BEAT_W   = 2 + KEEP_W + DATA_W;

  logic                clk_i = 1'b0;
  logic                rst_ni;
  logic                fifo_empty;
  logic [ENTRY_W-1:0]  fifo_rdata;
  logic                fifo_pop;
  logic                bridge_enable;
  logic                link_up;
  logic [7:0]          max_pkt_beats;
  logic [CREDIT_W-1:0] credit_init;
  logic                credit_return;
  logic                m_tx_valid;
  logic                m_tx_ready;
  logic [DATA_W-1:0]   m_tx_data;
  logic [KEEP_W-1:0]   m_tx_keep;
  logic                m_tx_last;
  logic                m_tx_hdr;
  logic [CREDIT_W-1:0] credits_avail;
  logic                pkt_sent_pulse;
  logic                ev_too_long;
  logic                ev_ovf;

  always #5 clk_i = ~clk_i;

  axi_bridge_ip_tx_egress #(
    .DATA_W   (DATA_W),
    .TUSER_W  (TUSER_W),
    .CREDIT_W (CREDIT_W)
  ) dut (
    .clk_i                     (clk_i),
    .rst_ni                    (rst_ni),
    .fifo_empty                (fifo_empty),
    .fifo_rdata                (fifo_rdata),
    .fifo_pop                  (fifo_pop),
    .bridge_enable             (bridge_enable),
    .link_up                   (link_up),
    .max_pkt_beats             (max_pkt_beats),
    .credit_init               (credit_init),
    .credit_return             (credit_return),
    .m_tx_valid                (m_tx_valid),
    .m_tx_ready                (m_tx_ready),
    .m_tx_data                 (m_tx_data),
    .m_tx_keep                 (m_tx_keep),
    .m_tx_last                 (m_tx_last),
    .m_tx_hdr                  (m_tx_hdr),
    .credits_avail             (credits_avail),
    .pkt_sent_pulse            (pkt_sent_pulse),
    .ev_err_pkt_too_long_pulse (ev_too_long),
    .ev_err_credit_ovf_pulse   (ev_ovf)
  );

  logic [ENTRY_W-1:0] fq[$];
  logic [BEAT_W-1:0]  obs[$];
  logic [BEAT_W-1:0]  expq[$];

  int chk_cnt  = 0;
  int err_cnt  = 0;
  int pop_cnt  = 0;
  int bad_pop  = 0;
  int sent_cnt = 0;
  int long_cnt = 0;
  int ovf_cnt  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [BEAT_W-1:0] hb(input logic [7:0] s, input logic [15:0] tu);
    return {1'b1, 1'b0, 4'hF, 8'h00, s, tu};
  endfunction

  function automatic logic [BEAT_W-1:0] db(input logic l, input logic [3:0] k, input logic [31:0] d);
    return {1'b0, l, k, d};
  endfunction

  function automatic logic [BEAT_W-1:0] obs_at(input int i);
    if (i < obs.size()) return obs[i];
    return '1;
  endfunction

  task automatic fifo_refresh();
    fifo_empty = (fq.size() == 0);
    fifo_rdata = (fq.size() != 0) ? fq[0] : '0;
  endtask

  // one clock: observe at negedge, then apply the FIFO pop just after the posedge
  task automatic tick();
    logic pop_now;
    @(negedge clk_i);
    pop_now = fifo_pop;
    if (fifo_pop) begin
      pop_cnt++;
      if (fifo_empty) bad_pop++;
    end
    if (m_tx_valid && m_tx_ready) obs.push_back({m_tx_hdr, m_tx_last, m_tx_keep, m_tx_data});
    if (pkt_sent_pulse) sent_cnt++;
    if (ev_too_long) long_cnt++;
    if (ev_ovf) ovf_cnt++;
    @(posedge clk_i);
    #1;
    if (pop_now && fq.size() != 0) void'(fq.pop_front());
    fifo_refresh();
  endtask

  task automatic push_pkt(input int n, input logic [15:0] tu, input logic [31:0] base,
                          input logic [3:0] last_keep);
    for (int i = 0; i < n; i++) begin
      logic       tl;
      logic [3:0] k;
      tl = (i == n - 1);
      k  = tl ? last_keep : 4'hF;
      fq.push_back({tl, tu, k, base + 32'(i)});
    end
    fifo_refresh();
  endtask

  task automatic link_cycle(input logic [CREDIT_W-1:0] init);
    link_up     = 1'b0;
    credit_init = init;
    repeat (2) tick();
    link_up = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while ((fq.size() != 0 || m_tx_valid) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain_to"}, 64'(n < budget), 64'd1);
    repeat (3) tick();
  endtask

  task automatic wait_obs(input string tag, input int cnt, input int budget);
    int n;
    n = 0;
    while (obs.size() < cnt && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_obs_to"}, 64'(n < budget), 64'd1);
  endtask

  task automatic chk_beats(input string tag);
    chk({tag, "_nbeats"}, 64'(obs.size()), 64'(expq.size()));
    foreach (expq[i]) chk($sformatf("%s_beat%0d", tag, i), 64'(obs_at(i)), 64'(expq[i]));
  endtask

  initial begin
    logic [BEAT_W+2:0]   snap;
    logic [BEAT_W+2:0]   cur;
    logic [CREDIT_W-1:0] snap_cred;
    logic [BEAT_W-1:0]   b;
    int                  pops0;
    int                  unstable;
    int                  seq_bad;

    rst_ni        = 1'b0;
    link_up       = 1'b0;
    bridge_enable = 1'b1;
    max_pkt_beats = 8'd0;
    credit_init   = 8'd8;
    credit_return = 1'b0;
    m_tx_ready    = 1'b1;
    fifo_refresh();
    repeat (3) tick();
    chk("rst_valid", 64'(m_tx_valid), 64'd0);
    chk("rst_credits", 64'(credits_avail), 64'd0);
    chk("rst_pop", 64'(fifo_pop), 64'd0);
    chk("rst_flags", 64'({pkt_sent_pulse, ev_too_long, ev_ovf, m_tx_last, m_tx_hdr}), 64'd0);
    rst_ni = 1'b1;

    // 1) basic 3-beat packet
    link_cycle(8'd8);
    chk("t1_credit_init", 64'(credits_avail), 64'd8);
    obs.delete(); expq.delete(); pop_cnt = 0; sent_cnt = 0;
    push_pkt(3, 16'h00A5, 32'h1000_0000, 4'h3);
    wait_drain("t1", 50);
    expq.push_back(hb(8'd0, 16'h00A5));
    expq.push_back(db(1'b0, 4'hF, 32'h1000_0000));
    expq.push_back(db(1'b0, 4'hF, 32'h1000_0001));
    expq.push_back(db(1'b1, 4'h3, 32'h1000_0002));
    chk_beats("t1");
    chk("t1_credits", 64'(credits_avail), 64'd4);
    chk("t1_pkt_sent", 64'(sent_cnt), 64'd1);
    chk("t1_pops", 64'(pop_cnt), 64'd3);

    // 2) credit starvation and resume
    link_cycle(8'd2);
    obs.delete(); expq.delete();
    push_pkt(4, 16'h1234, 32'h2000_0000, 4'hF);
    repeat (12) tick();
    chk("t2_stall_beats", 64'(obs.size()), 64'd2);
    chk("t2_stall_credits", 64'(credits_avail), 64'd0);
    chk("t2_stall_fifo", 64'(fq.size()), 64'd3);
    repeat (2) begin
      credit_return = 1'b1; tick(); credit_return = 1'b0;
      repeat (4) tick();
    end
    chk("t2_resume_beats", 64'(obs.size()), 64'd4);
    repeat (2) begin
      credit_return = 1'b1; tick(); credit_return = 1'b0;
      repeat (4) tick();
    end
    wait_drain("t2", 50);
    expq.push_back(hb(8'd1, 16'h1234));
    for (int i = 0; i < 4; i++) expq.push_back(db(i == 3, 4'hF, 32'h2000_0000 + 32'(i)));
    chk_beats("t2");
    chk("t2_credits", 64'(credits_avail), 64'd1);

    // 3) truncation at max_pkt_beats=2, then a normal packet
    link_cycle(8'd20);
    max_pkt_beats = 8'd2;
    obs.delete(); expq.delete(); pop_cnt = 0; long_cnt = 0;
    push_pkt(5, 16'h0BAD, 32'h3000_0000, 4'hF);
    push_pkt(1, 16'h0C0D, 32'h3100_0000, 4'h1);
    wait_drain("t3", 60);
    expq.push_back(hb(8'd2, 16'h0BAD));
    expq.push_back(db(1'b0, 4'hF, 32'h3000_0000));
    expq.push_back(db(1'b1, 4'hF, 32'h3000_0001));
    expq.push_back(hb(8'd3, 16'h0C0D));
    expq.push_back(db(1'b1, 4'h1, 32'h3100_0000));
    chk_beats("t3");
    chk("t3_too_long", 64'(long_cnt), 64'd1);
    chk("t3_pops", 64'(pop_cnt), 64'd6);
    chk("t3_credits", 64'(credits_avail), 64'd15);
    max_pkt_beats = 8'd0;

    // 4) backpressure mid-packet, then return coinciding with a load
    link_cycle(8'd10);
    obs.delete(); expq.delete(); pop_cnt = 0;
    push_pkt(4, 16'h4444, 32'h4000_0000, 4'hF);
    wait_obs("t4", 2, 50);
    m_tx_ready = 1'b0;
    tick();
    snap      = {m_tx_valid, m_tx_hdr, m_tx_last, m_tx_keep, m_tx_data};
    snap_cred = credits_avail;
    pops0     = pop_cnt;
    unstable  = 0;
    repeat (5) begin
      tick();
      cur = {m_tx_valid, m_tx_hdr, m_tx_last, m_tx_keep, m_tx_data};
      if (cur !== snap) unstable++;
    end
    chk("t4_hold_beat", 64'(snap), 64'({1'b1, 1'b0, 1'b0, 4'hF, 32'h4000_0001}));
    chk("t4_stable", 64'(unstable), 64'd0);
    chk("t4_stall_pops", 64'(pop_cnt - pops0), 64'd0);
    chk("t4_stall_credits", 64'(snap_cred), 64'd7);
    m_tx_ready    = 1'b1;
    credit_return = 1'b1;
    tick();
    credit_return = 1'b0;
    chk("t4_ret_and_load", 64'(credits_avail), 64'd7);
    wait_drain("t4", 50);
    expq.push_back(hb(8'd4, 16'h4444));
    for (int i = 0; i < 4; i++) expq.push_back(db(i == 3, 4'hF, 32'h4000_0000 + 32'(i)));
    chk_beats("t4");
    chk("t4_pops", 64'(pop_cnt), 64'd4);
    chk("t4_credits", 64'(credits_avail), 64'd6);

    // 5) saturation overflow, then 256 packets for sequence wrap
    link_cycle(8'hFF);
    chk("t5_credits_max", 64'(credits_avail), 64'hFF);
    ovf_cnt = 0;
    credit_return = 1'b1; tick(); credit_return = 1'b0;
    repeat (3) tick();
    chk("t5_sat_hold", 64'(credits_avail), 64'hFF);
    chk("t5_ovf_pulse", 64'(ovf_cnt), 64'd1);
    obs.delete();
    credit_return = 1'b1;
    for (int p = 0; p < 256; p++) push_pkt(1, 16'(p), 32'h5000_0000 + 32'(p), 4'hF);
    wait_drain("t5", 2000);
    credit_return = 1'b0;
    chk("t5_nbeats", 64'(obs.size()), 64'd512);
    seq_bad = 0;
    for (int i = 0; i < 256; i++) begin
      b = obs_at(2 * i);
      if (b !== hb(8'(5 + i), 16'(i))) seq_bad++;
    end
    chk("t5_seq_order", 64'(seq_bad), 64'd0);
    b = obs_at(500);
    chk("t5_seq_255", 64'(b[23:16]), 64'hFF);
    b = obs_at(502);
    chk("t5_seq_wrap", 64'(b[23:16]), 64'h00);

    // 6) link drop mid-packet, then bridge_enable low mid-packet
    link_cycle(8'd6);
    obs.delete(); expq.delete();
    push_pkt(6, 16'h6666, 32'h6000_0000, 4'hF);
    wait_obs("t6_drop", 2, 50);
    link_up = 1'b0;
    tick();
    chk("t6_down_valid", 64'(m_tx_valid), 64'd0);
    chk("t6_down_credits", 64'(credits_avail), 64'd6);
    chk("t6_down_pop", 64'(fifo_pop), 64'd0);
    fq.delete();
    fifo_refresh();
    link_up = 1'b1;
    tick();
    chk("t6_up_credits", 64'(credits_avail), 64'd6);
    obs.delete(); expq.delete();
    push_pkt(3, 16'h0077, 32'h7000_0000, 4'hF);
    push_pkt(1, 16'h0088, 32'h8000_0000, 4'hF);
    wait_obs("t6_en", 1, 50);
    bridge_enable = 1'b0;
    repeat (20) tick();
    chk("t6_en_beats", 64'(obs.size()), 64'd4);
    chk("t6_en_held_fifo", 64'(fq.size()), 64'd1);
    chk("t6_en_idle_valid", 64'(m_tx_valid), 64'd0);
    bridge_enable = 1'b1;
    wait_drain("t6", 50);
    expq.push_back(hb(8'd5, 16'h0077));
    for (int i = 0; i < 3; i++) expq.push_back(db(i == 2, 4'hF, 32'h7000_0000 + 32'(i)));
    expq.push_back(hb(8'd6, 16'h0088));
    expq.push_back(db(1'b1, 4'hF, 32'h8000_0000));
    chk_beats("t6");
    chk("t6_credits", 64'(credits_avail), 64'd0);

    chk("pop_when_empty", 64'(bad_pop), 64'd0);
    $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
    $finish;
  end

endmodule
